spi_link_monitor: RTL
=====================

Name: spi_link_monitor

Overview:
- Synthesizable, parametrised protocol monitor for the SPI slave. It runs on SysClk and samples the raw SPI pins alongside the slave's buffer and register-interface strobes.
- It decodes frames and commands, then checks rcMem/txMem address sequencing, register write enable timing and register write data.
- Violations are reported through sticky flags, a saturating counter and a first-error capture. It sits beside the SPI slave for in-silicon debug.

Parameters:
AddrBits, 12, width of rcMemAddr/txMemAddr
RegAddrBits, 4, width of regAddr
RegWordBytes, 4, bytes per register word; word width W = 8*RegWordBytes
CntBits, 8, width of err_count
CPOL, 0, 0 = sample on rising SPI_CLK, 1 = sample on falling SPI_CLK
WeWindow, 4, SysClk cycles after an event in which a strobe is legal/required

Ports:
SysClk  in  1  system clock
Reset  in  1  synchronous, active-low reset
SPI_CLK  in  1  raw SPI clock (async)
SPI_MOSI  in  1  raw SPI data in (async)
SPI_SS  in  1  raw slave select, active-low (async)
rcMemWE  in  1  slave rcMem write strobe
rcMemAddr  in  AddrBits  slave rcMem address
txMemAddr  in  AddrBits  slave txMem address
regWriteEn  in  1  slave register write strobe
regAddr  in  RegAddrBits  slave register address
regWriteData  in  W  slave register write data
err_clear  in  1  synchronous clear of error state
err_flags  out  6  sticky flags, bit n = error En
err_count  out  CntBits  saturating count of error cycles
first_err_valid  out  1  first_err_code is valid
first_err_code  out  3  lowest En set in first error cycle since clear
cmd_recvd  out  8  current frame command byte
byte_valid  out  1  1-cycle pulse per completed byte
frame_active  out  1  synchronised SS low and frame started

Behaviour:
- Reset low: all outputs 0, FSM IDLE, counters 0. Reset release with SS already low does not start a frame; a fresh SS fall is required.
- Synchroniser: SPI_CLK, SPI_MOSI and SPI_SS each pass through 2 flops. Sample edge = synced-clock edge selected by CPOL, detected against a third flop.
- Bit capture: MSB first. The 8th sample sets byte_valid high on the following SysClk (pin-to-pulse ≤ 4 cycles). The bit counter wraps to 0.
- FSM states: IDLE, CMD, DATA_RC, DATA_TX, REG_BUILD, REG_SEND, IGNORE.
  - IDLE -> CMD on synced SS fall; bit and byte counters cleared; frame_active=1.
  - CMD byte_valid: latch cmd_recvd, then branch:
    - 0x01/0x02 -> DATA_RC
    - 0x03/0x04 -> DATA_TX
    - cmd[7:6]=11 -> REG_BUILD
    - cmd[7:6]=10 -> REG_SEND
    - else -> IGNORE
  - Any state -> IDLE on synced SS rise. frame_active=0; cmd_recvd holds its value.
- Checks (a flag is set in the cycle the violation is detected):
  - E0 WE_STRAY: rcMemWE=1 with no byte_valid in the last WeWindow cycles, or state not in {CMD→DATA_RC transition, DATA_RC, REG_SEND}.
  - E1 RC_ADDR: cycle after rcMemWE, rcMemAddr != prev+1 mod 2^AddrBits. Wrap from all-ones to 0 is legal.
  - E2 TX_ADDR: in DATA_TX, at each data byte_valid after the first, txMemAddr != value latched at previous byte_valid +1 mod 2^AddrBits. The first data byte only latches.
  - E3 REG_WE: in REG_BUILD, regWriteEn absent within WeWindow cycles after the RegWordBytes-th data byte. Also raised for regWriteEn=1 outside that window. Bytes beyond RegWordBytes are ignored.
  - E4 REG_DATA: regWriteEn=1 and (regWriteData != assembled word, or regAddr != cmd_recvd[RegAddrBits-1:0]).
  - E5 PARTIAL: SS rises with bit counter ≠ 0.
- Error bookkeeping:
  - err_flags OR in new detections.
  - err_count +1 per cycle with ≥1 detection; saturates at all-ones.
  - first_err captured only when first_err_valid=0.
  - err_clear zeroes flags, count and first_err. A detection in the same cycle wins: flags = new, count = 1, first_err = new.

Test Plan:
- CPOL=0; frame 0x01 + 3 bytes; slave rcMemAddr 0x000→0x001→0x002→0x003 with WE 2 cycles after each byte -> err_flags=0, 4 byte_valid pulses, cmd_recvd=0x01.
- rcMemAddr 0xFFF then WE -> 0x000 -> no E1; rcMemAddr jumps 0x010→0x012 -> err_flags=0x02, err_count=1, first_err_code=1.
- Cmd 0xC5, 4 bytes DE AD BE EF; regWriteEn 3 cycles after 4th byte, regAddr=5, data 0xDEADBEEF -> no error. Repeat with data 0xDEADBEEE -> E4. Repeat with no regWriteEn -> E3 at WeWindow expiry.
- SS rises after 5 bits -> E5 set, FSM IDLE; next SS fall -> new frame decodes normally.
- Force 300 error cycles with CntBits=8 -> err_count=255; err_clear in same cycle as E2 detection -> flags=0x04, count=1, first_err_code=2.
- CPOL=1, byte 0xA5 on falling edges -> byte_valid once, captured 0xA5; Reset low mid-frame -> outputs 0, no byte_valid until next SS fall.

Source files
------------

// File: rtl/spi_link_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_link_monitor
// Brief    : Passive SPI slave protocol monitor: frame/command decode plus
//            buffer-address, register-strobe and register-data checking.
// Revision : 1.0 - initial release
// ============================================================================
module spi_link_monitor #(
    parameter int AddrBits     = 12,
    parameter int RegAddrBits  = 4,
    parameter int RegWordBytes = 4,
    parameter int CntBits      = 8,
    parameter int CPOL         = 0,
    parameter int WeWindow     = 4
) (
    input  logic                        SysClk,
    input  logic                        Reset,
    input  logic                        SPI_CLK,
    input  logic                        SPI_MOSI,
    input  logic                        SPI_SS,
    input  logic                        rcMemWE,
    input  logic [AddrBits-1:0]         rcMemAddr,
    input  logic [AddrBits-1:0]         txMemAddr,
    input  logic                        regWriteEn,
    input  logic [RegAddrBits-1:0]      regAddr,
    input  logic [8*RegWordBytes-1:0]   regWriteData,
    input  logic                        err_clear,
    output logic [5:0]                  err_flags,
    output logic [CntBits-1:0]          err_count,
    output logic                        first_err_valid,
    output logic [2:0]                  first_err_code,
    output logic [7:0]                  cmd_recvd,
    output logic                        byte_valid,
    output logic                        frame_active
);

    localparam int c_W       = 8 * RegWordBytes;
    localparam int c_AGE_W   = $clog2(WeWindow + 2);
    localparam int c_WIN_W   = $clog2(WeWindow + 1);
    localparam int c_RB_W    = $clog2(RegWordBytes + 1);
    localparam logic                c_CLK_IDLE = (CPOL != 0);
    localparam logic [c_AGE_W-1:0]  c_AGE_MAX  = c_AGE_W'(WeWindow + 1);
    localparam logic [c_AGE_W-1:0]  c_AGE_WIN  = c_AGE_W'(WeWindow);
    localparam logic [c_WIN_W-1:0]  c_WIN_LEN  = c_WIN_W'(WeWindow);
    localparam logic [c_WIN_W-1:0]  c_WIN_ONE  = c_WIN_W'(1);
    localparam logic [c_RB_W-1:0]   c_RB_LAST  = c_RB_W'(RegWordBytes - 1);
    localparam logic [c_RB_W-1:0]   c_RB_FULL  = c_RB_W'(RegWordBytes);
    localparam logic [CntBits-1:0]  c_CNT_MAX  = '1;
    localparam logic [CntBits-1:0]  c_CNT_ONE  = CntBits'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_DATA_RC   = 3'd2,
        S_DATA_TX   = 3'd3,
        S_REG_BUILD = 3'd4,
        S_REG_SEND  = 3'd5,
        S_IGNORE    = 3'd6
    } state_t;

    state_t               r_state, w_state_next;
    logic [2:0]           r_clk_sync, r_ss_sync;
    logic [1:0]           r_mosi_sync;
    logic                 w_sample, w_ss_fall, w_ss_rise, w_mosi;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift, r_byte, r_cmd;
    logic                 r_byte_valid;
    logic [c_RB_W-1:0]    r_reg_cnt;
    logic [c_W-1:0]       r_word, w_word_shift;
    logic                 w_word_last;
    logic [c_WIN_W-1:0]   r_win;
    logic [c_AGE_W-1:0]   r_bv_age;
    logic                 r_we_d;
    logic [AddrBits-1:0]  r_we_addr, r_tx_addr;
    logic                 r_tx_have, w_tx_byte, w_bv_recent, w_we_state_ok;
    logic [5:0]           w_det, r_err_flags;
    logic                 w_any;
    logic [2:0]           w_first;
    logic [CntBits-1:0]   r_err_count;
    logic                 r_first_valid;
    logic [2:0]           r_first_code;

    // Pins are asynchronous; the third stage of clk/ss is the edge reference.
    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_clk_sync  <= {3{c_CLK_IDLE}};
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], SPI_CLK};
            r_mosi_sync <= {r_mosi_sync[0], SPI_MOSI};
            r_ss_sync   <= {r_ss_sync[1:0], SPI_SS};
        end
    end

    generate
        if (CPOL == 0) begin : g_edge_rise
            assign w_sample = r_clk_sync[1] & ~r_clk_sync[2];
        end else begin : g_edge_fall
            assign w_sample = ~r_clk_sync[1] & r_clk_sync[2];
        end
    endgenerate

    assign w_ss_fall = ~r_ss_sync[1] &  r_ss_sync[2];
    assign w_ss_rise =  r_ss_sync[1] & ~r_ss_sync[2];
    assign w_mosi    =  r_mosi_sync[1];

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == S_IDLE) begin
            if (w_ss_fall) begin
                w_state_next = S_CMD;
            end
        end else if (w_ss_rise) begin
            w_state_next = S_IDLE;
        end else if (r_state == S_CMD && r_byte_valid) begin
            if (r_cmd == 8'h01 || r_cmd == 8'h02) begin
                w_state_next = S_DATA_RC;
            end else if (r_cmd == 8'h03 || r_cmd == 8'h04) begin
                w_state_next = S_DATA_TX;
            end else if (r_cmd[7:6] == 2'b11) begin
                w_state_next = S_REG_BUILD;
            end else if (r_cmd[7:6] == 2'b10) begin
                w_state_next = S_REG_SEND;
            end else begin
                w_state_next = S_IGNORE;
            end
        end
    end

    // The command latches with the 8th bit so the branch sees it with byte_valid.
    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_cmd        <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (r_state == S_IDLE || w_ss_rise) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_shift   <= {r_shift[6:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_byte       <= {r_shift[6:0], w_mosi};
                    if (r_state == S_CMD) begin
                        r_cmd <= {r_shift[6:0], w_mosi};
                    end
                end
            end
        end
    end

    generate
        if (RegWordBytes == 1) begin : g_word_single
            assign w_word_shift = r_byte;
        end else begin : g_word_multi
            assign w_word_shift = {r_word[c_W-9:0], r_byte};
        end
    endgenerate

    assign w_word_last = (r_state == S_REG_BUILD) && r_byte_valid && (r_reg_cnt == c_RB_LAST);
    assign w_tx_byte   = (r_state == S_DATA_TX) && r_byte_valid;

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_reg_cnt <= '0;
            r_word    <= '0;
            r_win     <= '0;
            r_bv_age  <= c_AGE_MAX;
            r_we_d    <= 1'b0;
            r_we_addr <= '0;
            r_tx_have <= 1'b0;
            r_tx_addr <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_reg_cnt <= '0;
            end else if (r_state == S_REG_BUILD && r_byte_valid && r_reg_cnt < c_RB_FULL) begin
                r_word    <= w_word_shift;
                r_reg_cnt <= r_reg_cnt + 1'b1;
            end
            // Window opens the cycle after the last word byte and closes on the strobe.
            if (w_word_last) begin
                r_win <= c_WIN_LEN;
            end else if (r_win != '0) begin
                r_win <= regWriteEn ? '0 : r_win - 1'b1;
            end
            if (r_byte_valid) begin
                r_bv_age <= c_AGE_W'(1);
            end else if (r_bv_age != c_AGE_MAX) begin
                r_bv_age <= r_bv_age + 1'b1;
            end
            r_we_d    <= rcMemWE;
            r_we_addr <= rcMemAddr;
            if (r_state == S_IDLE) begin
                r_tx_have <= 1'b0;
            end else if (w_tx_byte) begin
                r_tx_have <= 1'b1;
                r_tx_addr <= txMemAddr;
            end
        end
    end

    assign w_bv_recent   = r_byte_valid || (r_bv_age <= c_AGE_WIN);
    assign w_we_state_ok = (r_state == S_DATA_RC) || (r_state == S_REG_SEND) ||
                           (r_state == S_CMD && w_state_next == S_DATA_RC);

    always_comb begin
        w_det    = '0;
        w_det[0] = rcMemWE && (!w_bv_recent || !w_we_state_ok);
        w_det[1] = r_we_d && (rcMemAddr != r_we_addr + 1'b1);
        w_det[2] = w_tx_byte && r_tx_have && (txMemAddr != r_tx_addr + 1'b1);
        w_det[3] = (r_win == c_WIN_ONE && !regWriteEn) || (regWriteEn && r_win == '0);
        w_det[4] = regWriteEn && ((regWriteData != r_word) ||
                                  (regAddr != r_cmd[RegAddrBits-1:0]));
        w_det[5] = w_ss_rise && (r_state != S_IDLE) && (r_bit_cnt != 3'd0);
    end

    assign w_any = |w_det;

    always_comb begin
        w_first = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_det[i]) begin
                w_first = 3'(i);
            end
        end
    end

    // A detection coincident with err_clear survives the clear.
    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            r_err_flags   <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_code  <= '0;
        end else if (err_clear) begin
            r_err_flags   <= w_det;
            r_err_count   <= w_any ? c_CNT_ONE : '0;
            r_first_valid <= w_any;
            r_first_code  <= w_any ? w_first : 3'd0;
        end else begin
            r_err_flags <= r_err_flags | w_det;
            if (w_any && r_err_count != c_CNT_MAX) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (w_any && !r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_code  <= w_first;
            end
        end
    end

    assign err_flags       = r_err_flags;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_code  = r_first_code;
    assign cmd_recvd       = r_cmd;
    assign byte_valid      = r_byte_valid;
    assign frame_active    = (r_state != S_IDLE);

endmodule
`default_nettype wire
